// File: rtl/instruction_fetch.sv
// Instruction fetch unit: holds the PC, issues one read at a time on a
// variable-latency memory port and hands each fetched word to the decoder
// with a valid/ready handshake. Execute-stage redirects retarget the PC and
// squash any read still in flight.
module instruction_fetch #(
   parameter int unsigned                 ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0]       RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // memory read port
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [31:0]           mem_rdata,
   // redirect from execute
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   // decoder side
   input  logic                  decode_ready,
   output logic                  instr_valid,
   output logic [31:0]           instruction,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic                  misaligned
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic                  r_squash;
   logic                  r_mem_req;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic                  r_instr_valid;
   logic [31:0]           r_instruction;
   logic [ADDR_WIDTH-1:0] r_instr_pc;
   logic                  r_misaligned;

   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] w_pc_nxt;
   logic                  w_squash_nxt;
   logic                  w_mem_req_nxt;
   logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
   logic                  w_instr_valid_nxt;
   logic [31:0]           w_instruction_nxt;
   logic [ADDR_WIDTH-1:0] w_instr_pc_nxt;
   logic                  w_misaligned_nxt;

   logic [ADDR_WIDTH-1:0] w_redirect_aligned;
   logic [ADDR_WIDTH-1:0] w_pc_plus4;

   assign w_redirect_aligned = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
   // Natural overflow of the adder gives the required wrap to address 0.
   assign w_pc_plus4         = r_pc + ADDR_WIDTH'(4);

   // Next-state and next-output decode; redirect outranks every other event.
   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path can
      // leave one unassigned and infer a latch.
      w_state_nxt       = r_state;
      w_pc_nxt          = r_pc;
      w_squash_nxt      = r_squash;
      w_mem_req_nxt     = 1'b0;
      w_mem_addr_nxt    = r_mem_addr;
      w_instr_valid_nxt = r_instr_valid;
      w_instruction_nxt = r_instruction;
      w_instr_pc_nxt    = r_instr_pc;
      w_misaligned_nxt  = r_misaligned;

      if (redirect_valid) begin
         w_pc_nxt          = w_redirect_aligned;
         w_misaligned_nxt  = |redirect_pc[1:0];
         w_instr_valid_nxt = 1'b0;
         case (r_state)
            S_IDLE, S_HOLD: w_state_nxt = S_REQ;
            S_REQ: begin
               // The old-address strobe is already out; its data must be dropped.
               w_squash_nxt = 1'b1;
               w_state_nxt  = S_WAIT;
            end
            S_WAIT: begin
               if (mem_ack) begin
                  // Outstanding read completes now and is discarded on the spot.
                  w_squash_nxt = 1'b0;
                  w_state_nxt  = S_REQ;
               end else begin
                  w_squash_nxt = 1'b1;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end else begin
         case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ:  w_state_nxt = S_WAIT;
            S_WAIT: begin
               if (mem_ack) begin
                  if (r_squash) begin
                     w_squash_nxt = 1'b0;
                     w_state_nxt  = S_REQ;
                  end else begin
                     w_instruction_nxt = mem_rdata;
                     w_instr_pc_nxt    = r_pc;
                     w_instr_valid_nxt = 1'b1;
                     w_pc_nxt          = w_pc_plus4;
                     w_state_nxt       = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (decode_ready) begin
                  w_instr_valid_nxt = 1'b0;
                  w_state_nxt       = S_REQ;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end

      // Every entry into REQ raises the strobe for one cycle with the PC that
      // will be current there, so redirected and sequential fetches agree.
      if (w_state_nxt == S_REQ) begin
         w_mem_req_nxt  = 1'b1;
         w_mem_addr_nxt = w_pc_nxt;
      end
   end

   // State and registered outputs; reset abandons any read in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_pc          <= RESET_PC;
         r_squash      <= 1'b0;
         r_mem_req     <= 1'b0;
         r_mem_addr    <= RESET_PC;
         r_instr_valid <= 1'b0;
         r_instruction <= NOP;
         r_instr_pc    <= '0;
         r_misaligned  <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register samples the values
         // from before this edge, independent of statement order.
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_squash      <= w_squash_nxt;
         r_mem_req     <= w_mem_req_nxt;
         r_mem_addr    <= w_mem_addr_nxt;
         r_instr_valid <= w_instr_valid_nxt;
         r_instruction <= w_instruction_nxt;
         r_instr_pc    <= w_instr_pc_nxt;
         r_misaligned  <= w_misaligned_nxt;
      end
   end

   assign mem_req     = r_mem_req;
   assign mem_addr    = r_mem_addr;
   assign instr_valid = r_instr_valid;
   assign instruction = r_instruction;
   assign instr_pc    = r_instr_pc;
   assign misaligned  = r_misaligned;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a latency-programmable memory responder, a
// scoreboard of expected read addresses and delivered instructions, and a
// directed sequence covering reset, stalls, redirects, PC wrap and async reset.
module tb_instruction_fetch;

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
   } instr_t;

   logic        clk;
   logic        rst_n;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        decode_ready;
   logic        instr_valid;
   logic [31:0] instruction;
   logic [31:0] instr_pc;
   logic        misaligned;

   int n_checks = 0;
   int n_pass   = 0;
   int lat      = 1;

   logic [31:0] exp_req[$];
   instr_t      exp_instr[$];

   instruction_fetch #(
      .ADDR_WIDTH (32),
      .RESET_PC   (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .decode_ready   (decode_ready),
      .instr_valid    (instr_valid),
      .instruction    (instruction),
      .instr_pc       (instr_pc),
      .misaligned     (misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      case (addr)
         32'h0000_0000: return 32'h0050_0093;
         32'h0000_0004: return 32'h00A0_0113;
         32'h0000_0008: return 32'hDEAD_BEEF;
         32'h0000_0100: return 32'h0640_0193;
         32'h0000_0200: return 32'h00C0_0213;
         32'hFFFF_FFFC: return 32'h0010_0073;
         default:       return 32'h0000_0013;
      endcase
   endfunction

   // Memory responder: captures a request, acks it `lat` cycles later.
   initial begin
      logic        pend;
      int          cnt;
      logic [31:0] raddr;
      pend      = 1'b0;
      cnt       = 0;
      raddr     = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) pend = 1'b0;
         else if (mem_req) begin
            pend  = 1'b1;
            cnt   = lat - 1;
            raddr = mem_addr;
         end
         @(posedge clk);
         #1;
         mem_ack = 1'b0;
         if (pend && rst_n) begin
            if (cnt == 0) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_word(raddr);
               pend      = 1'b0;
            end else begin
               cnt--;
            end
         end
      end
   end

   // Monitor: pops the scoreboard whenever a request or a handshake appears.
   initial begin
      logic [31:0] ea;
      instr_t      ei;
      forever begin
         @(negedge clk);
         if (mem_req) begin
            if (exp_req.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_req: got addr %h, required no request", mem_addr);
            end else begin
               ea = exp_req.pop_front();
               check("req_addr", mem_addr, ea);
            end
         end
         if (instr_valid && decode_ready) begin
            if (exp_instr.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_instr: got %h at pc %h, required no delivery", instruction, instr_pc);
            end else begin
               ei = exp_instr.pop_front();
               check("instr_word", instruction, ei.word);
               check("instr_pc", instr_pc, ei.pc);
            end
         end
      end
   end

   task automatic wait_req(input string name);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = mem_req;
      end
      if (!seen) begin
         n_checks++;
         $display("FAIL %s: got no mem_req in 50 cycles, required one", name);
      end
   endtask

   task automatic wait_valid(input string name);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = instr_valid;
      end
      if (!seen) begin
         n_checks++;
         $display("FAIL %s: got no instr_valid in 50 cycles, required one", name);
      end
   endtask

   task automatic accept();
      @(posedge clk);
      #1;
      decode_ready = 1'b1;
      @(posedge clk);
      #1;
      decode_ready = 1'b0;
   endtask

   task automatic do_redirect(input logic [31:0] target);
      @(posedge clk);
      #1;
      redirect_valid = 1'b1;
      redirect_pc    = target;
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_mem_req"},     {31'd0, mem_req},     32'd0);
      check({tag, "_mem_addr"},    mem_addr,             32'h0000_0000);
      check({tag, "_instr_valid"}, {31'd0, instr_valid}, 32'd0);
      check({tag, "_instruction"}, instruction,          32'h0000_0013);
      check({tag, "_instr_pc"},    instr_pc,             32'h0000_0000);
      check({tag, "_misaligned"},  {31'd0, misaligned},  32'd0);
   endtask

   initial begin
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      decode_ready   = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");

      // 1: first fetch with ready high, 1-cycle memory
      decode_ready = 1'b1;
      lat          = 1;
      exp_req.push_back(32'h0000_0000);
      exp_instr.push_back('{word: 32'h0050_0093, pc: 32'h0000_0000});
      exp_req.push_back(32'h0000_0004);
      rst_n = 1'b1;
      @(negedge clk);
      check("t1_bubble", {31'd0, mem_req}, 32'd0);
      @(negedge clk);
      check("t1_first_req", {31'd0, mem_req}, 32'd1);
      wait_valid("t1_valid");
      @(posedge clk);
      #1;
      decode_ready = 1'b0;

      // 2: decoder stalls five cycles in HOLD
      exp_instr.push_back('{word: 32'h00A0_0113, pc: 32'h0000_0004});
      exp_req.push_back(32'h0000_0008);
      wait_valid("t2_valid");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t2_hold_valid", {31'd0, instr_valid}, 32'd1);
         check("t2_hold_word",  instruction,          32'h00A0_0113);
         check("t2_hold_pc",    instr_pc,             32'h0000_0004);
         check("t2_hold_noreq", {31'd0, mem_req},     32'd0);
      end
      lat = 3;
      accept();

      // 3: redirect during WAIT; late ack data must vanish
      exp_req.push_back(32'h0000_0100);
      wait_req("t3_req8");
      do_redirect(32'h0000_0100);
      wait_req("t3_req100");
      check("t3_misaligned", {31'd0, misaligned}, 32'd0);
      wait_valid("t3_valid");
      exp_instr.push_back('{word: 32'h0640_0193, pc: 32'h0000_0100});
      exp_req.push_back(32'h0000_0104);
      lat = 1;
      accept();

      // 4: misaligned redirect coincident with the ack
      exp_req.push_back(32'h0000_0100);
      wait_req("t4_req104");
      do_redirect(32'h0000_0102);
      wait_req("t4_req100");
      check("t4_misaligned_set", {31'd0, misaligned}, 32'd1);
      wait_valid("t4_valid");
      check("t4_misaligned_sticky", {31'd0, misaligned}, 32'd1);
      check("t4_word", instruction, 32'h0640_0193);
      check("t4_pc",   instr_pc,    32'h0000_0100);
      exp_req.push_back(32'h0000_0200);
      do_redirect(32'h0000_0200);
      @(negedge clk);
      check("t4_misaligned_clr", {31'd0, misaligned},  32'd0);
      check("t4_valid_dropped",  {31'd0, instr_valid}, 32'd0);

      // 5: PC wrap from the top of the address space
      wait_valid("t5_valid200");
      exp_instr.push_back('{word: 32'h00C0_0213, pc: 32'h0000_0200});
      exp_req.push_back(32'h0000_0204);
      accept();
      wait_valid("t5_valid204");
      exp_req.push_back(32'hFFFF_FFFC);
      do_redirect(32'hFFFF_FFFE);
      @(negedge clk);
      check("t5_misaligned", {31'd0, misaligned}, 32'd1);
      wait_valid("t5_validtop");
      exp_instr.push_back('{word: 32'h0010_0073, pc: 32'hFFFF_FFFC});
      exp_req.push_back(32'h0000_0000);
      lat = 4;
      accept();

      // 6: asynchronous reset while a read is outstanding
      wait_req("t6_req0");
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_values("t6_async");
      repeat (2) @(posedge clk);
      #1;
      lat = 2;
      exp_req.push_back(32'h0000_0000);
      rst_n = 1'b1;
      wait_req("t6_refetch");
      wait_valid("t6_valid");
      exp_instr.push_back('{word: 32'h0050_0093, pc: 32'h0000_0000});
      exp_req.push_back(32'h0000_0004);
      accept();
      wait_req("t6_req4");
      @(negedge clk);

      check("leftover_req",   exp_req.size(),   32'd0);
      check("leftover_instr", exp_instr.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
